// File: rtl/shift_ring_counter.sv
// shift_ring_counter: parametrised one-hot ring / Johnson shift counter.
// Provides a phase index, a wrap pulse, illegal-state detection and
// optional self-correction back to the mode seed. It is intended as a
// strobe generator for multi-phase control.
module shift_ring_counter #(
    parameter int WIDTH        = 4,
    parameter bit SELF_CORRECT = 1'b1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          en,
    input  logic                          dir,
    input  logic                          load,
    input  logic                          mode,
    input  logic [WIDTH-1:0]              load_val,
    output logic [WIDTH-1:0]              R,
    output logic [$clog2(2*WIDTH)-1:0]    phase,
    output logic                          wrap,
    output logic                          illegal
);

    localparam int PW = $clog2(2*WIDTH);

    // Ring seed is a single one in the MSB; the Johnson seed is all zeros.
    localparam logic [WIDTH-1:0] SEED_RING = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [PW-1:0]    PMAX_RING = PW'(WIDTH - 1);
    localparam logic [PW-1:0]    PMAX_JOHN = PW'(2*WIDTH - 1);

    logic            mode_q;
    logic [WIDTH-1:0] seed;
    logic [WIDTH-1:0] r_shift;
    logic             fbit;
    logic [PW-1:0]    pmax;
    logic [PW-1:0]    phase_nxt;
    logic             wrap_nxt;

    // Legality check: ring needs exactly one set bit. Johnson allows at most
    // one boundary between adjacent bits.
    always_comb begin
        int ones;
        int trans;
        ones  = 0;
        trans = 0;
        for (int i = 0; i < WIDTH; i++) begin
            if (R[i]) ones++;
        end
        for (int i = 0; i < WIDTH-1; i++) begin
            if (R[i] != R[i+1]) trans++;
        end
        illegal = mode_q ? (trans > 1) : (ones != 1);
    end

    // Shift datapath: the feedback bit is inverted in Johnson mode.
    always_comb begin
        fbit    = (dir ? R[WIDTH-1] : R[0]) ^ mode_q;
        r_shift = dir ? {R[WIDTH-2:0], fbit} : {fbit, R[WIDTH-1:1]};
        seed    = mode_q ? '0 : SEED_RING;
    end

    // Phase tracking: count up toward the LSB, count down toward the MSB.
    // Flag a wrap on crossing the period boundary.
    always_comb begin
        pmax      = mode_q ? PMAX_JOHN : PMAX_RING;
        phase_nxt = phase;
        wrap_nxt  = 1'b0;
        if (!dir) begin
            if (phase == pmax) begin
                phase_nxt = '0;
                wrap_nxt  = 1'b1;
            end else begin
                phase_nxt = phase + 1'b1;
            end
        end else begin
            if (phase == '0) begin
                phase_nxt = pmax;
                wrap_nxt  = 1'b1;
            end else begin
                phase_nxt = phase - 1'b1;
            end
        end
    end

    // State register. Priority is reset, then load, then enable (correct or
    // shift), then hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            R      <= SEED_RING;
            mode_q <= 1'b0;
            phase  <= '0;
            wrap   <= 1'b0;
        end else if (load) begin
            R      <= load_val;
            mode_q <= mode;
            phase  <= '0;
            wrap   <= 1'b0;
        end else if (en) begin
            if (SELF_CORRECT && illegal) begin
                R     <= seed;
                phase <= '0;
                wrap  <= 1'b0;
            end else begin
                R     <= r_shift;
                phase <= phase_nxt;
                wrap  <= wrap_nxt;
            end
        end else begin
            wrap <= 1'b0;
        end
    end

endmodule

// File: tb/tb_shift_ring_counter.sv
// Directed bench for shift_ring_counter (WIDTH 4). A second instance with
// self-correction disabled shares the same stimulus.
module tb_shift_ring_counter;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b0;
    logic       dir = 1'b0;
    logic       load = 1'b0;
    logic       mode = 1'b0;
    logic [3:0] load_val = '0;

    logic [3:0] R, R_nc;
    logic [2:0] phase, phase_nc;
    logic       wrap, wrap_nc;
    logic       illegal, illegal_nc;

    int nchk = 0;
    int nerr = 0;

    shift_ring_counter #(.WIDTH(4), .SELF_CORRECT(1'b1)) dut (
        .clk(clk), .reset(reset), .en(en), .dir(dir), .load(load),
        .mode(mode), .load_val(load_val), .R(R), .phase(phase),
        .wrap(wrap), .illegal(illegal)
    );

    shift_ring_counter #(.WIDTH(4), .SELF_CORRECT(1'b0)) dut_nc (
        .clk(clk), .reset(reset), .en(en), .dir(dir), .load(load),
        .mode(mode), .load_val(load_val), .R(R_nc), .phase(phase_nc),
        .wrap(wrap_nc), .illegal(illegal_nc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] jseq [8] = '{4'b1000, 4'b1100, 4'b1110, 4'b1111,
                             4'b0111, 4'b0011, 4'b0001, 4'b0000};
    logic [3:0] rseq [5] = '{4'b0100, 4'b0010, 4'b0001, 4'b1000, 4'b0100};
    logic [2:0] rph  [5] = '{3'd1, 3'd2, 3'd3, 3'd0, 3'd1};

    initial begin
        // async reset, checked before any clock edge
        #1 reset = 1'b1;
        #1;
        chk("rst_R", R, 4'b1000);
        chk("rst_phase", phase, 0);
        chk("rst_wrap", wrap, 0);
        chk("rst_illegal", illegal, 0);
        tick();
        reset = 1'b0;
        tick();
        chk("hold_R", R, 4'b1000);

        // ring sweep toward LSB
        en = 1'b1;
        dir = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("ring_R%0d", i), R, rseq[i]);
            chk($sformatf("ring_ph%0d", i), phase, rph[i]);
            chk($sformatf("ring_wr%0d", i), wrap, (i == 3) ? 1 : 0);
        end
        en = 1'b0;

        // reset between edges aborts mid-sweep
        reset = 1'b1;
        #1;
        chk("midrst_R", R, 4'b1000);
        chk("midrst_phase", phase, 0);
        reset = 1'b0;

        // reverse direction from the ring seed
        en = 1'b1;
        dir = 1'b1;
        tick();
        chk("rev_R0", R, 4'b0001);
        chk("rev_ph0", phase, 3);
        chk("rev_wr0", wrap, 1);
        tick();
        chk("rev_R1", R, 4'b0010);
        chk("rev_ph1", phase, 2);
        chk("rev_wr1", wrap, 0);
        en = 1'b0;
        dir = 1'b0;
        tick();
        chk("idle_wrap", wrap, 0);

        // Johnson sweep
        load = 1'b1;
        mode = 1'b1;
        load_val = 4'b0000;
        tick();
        chk("jld_R", R, 0);
        chk("jld_phase", phase, 0);
        load = 1'b0;
        en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("john_R%0d", i), R, jseq[i]);
            chk($sformatf("john_ph%0d", i), phase, (i + 1) % 8);
            chk($sformatf("john_wr%0d", i), wrap, (i == 7) ? 1 : 0);
            chk($sformatf("john_il%0d", i), illegal, 0);
        end

        // one more shift so phase is nonzero, then load and en together
        tick();
        chk("pre_ld_ph", phase, 1);
        load = 1'b1;
        mode = 1'b0;
        load_val = 4'b0100;
        tick();
        chk("ldpri_R", R, 4'b0100);
        chk("ldpri_ph", phase, 0);
        chk("ldpri_wr", wrap, 0);
        load = 1'b0;
        en = 1'b0;

        // illegal ring state: held while idle, corrected (or not) on enable
        load = 1'b1;
        load_val = 4'b1010;
        tick();
        chk("ilr_flag", illegal, 1);
        chk("ilr_flag_nc", illegal_nc, 1);
        load = 1'b0;
        tick();
        chk("ilr_hold_R", R, 4'b1010);
        chk("ilr_hold_flag", illegal, 1);
        en = 1'b1;
        tick();
        chk("ilr_fix_R", R, 4'b1000);
        chk("ilr_fix_ph", phase, 0);
        chk("ilr_fix_il", illegal, 0);
        chk("ilr_nc_R", R_nc, 4'b0101);
        chk("ilr_nc_il", illegal_nc, 1);
        en = 1'b0;

        // illegal Johnson state
        load = 1'b1;
        mode = 1'b1;
        load_val = 4'b0100;
        tick();
        chk("ilj_flag", illegal, 1);
        load = 1'b0;
        en = 1'b1;
        tick();
        chk("ilj_fix_R", R, 4'b0000);
        chk("ilj_fix_ph", phase, 0);
        chk("ilj_fix_il", illegal, 0);
        en = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", nchk, nerr);
        $finish;
    end

endmodule

// File: doc/shift_ring_counter.md
# shift_ring_counter

Parametrised one-hot ring / Johnson (twisted-ring) shift counter. It replaces the fixed 4-bit ring counter with:
- configurable width and a selectable ring or Johnson sequence,
- shift direction control, shift enable and parallel load,
- a phase index with a wrap pulse, and illegal-state detection with optional self-correction.

It serves as a sequencing/strobe generator for multi-phase control logic.

## Interface
- WIDTH, 4, number of state bits; legal range ≥ 2
- SELF_CORRECT, 1, 1 = an illegal state is replaced by the mode seed on the next enabled shift; 0 = illegal states shift freely
- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-high reset
- en  input  1  shift enable; one shift per clock while high
- dir  input  1  0 = shift toward LSB, 1 = shift toward MSB
- load  input  1  synchronous parallel load of load_val and mode
- mode  input  1  sequence select, captured only on load: 0 = ring, 1 = Johnson
- load_val  input  WIDTH  value written to R on load
- R  output  WIDTH  counter state (registered)
- phase  output  $clog2(2*WIDTH)  shift position index within the period (registered)
- wrap  output  1  one-cycle pulse on period wrap (registered)
- illegal  output  1  current R is not a legal state for the captured mode (combinational from R and mode_q)

## Operation
- Internal register mode_q holds the active mode. It is written only by load.
- Period P: WIDTH in ring mode, 2*WIDTH in Johnson mode.
- Seed (the legal starting state of each mode):
  - ring: R = 1 << (WIDTH-1), e.g. 1000 for WIDTH = 4
  - Johnson: R = all zeros
- Priority per edge: reset > load > en > hold.
- Shift with dir = 0:
  - R[WIDTH-1] <= fb(R[0]); R[i] <= R[i+1] for i < WIDTH-1
  - fb(x) = x in ring mode, ~x in Johnson mode
- Shift with dir = 1:
  - R[0] <= fb(R[WIDTH-1]); R[i] <= R[i-1] for i > 0
- dir may change on any cycle; each shift uses the dir sampled at that edge.
- Phase tracking:
  - dir = 0: phase increments modulo P.
  - dir = 1: phase decrements modulo P.
  - wrap <= 1 on the edge where phase moves P-1 → 0 (up) or 0 → P-1 (down); otherwise wrap <= 0.
- Legality:
  - ring: popcount(R) == 1
  - Johnson: at most one index i in 0..WIDTH-2 with R[i] != R[i+1]
- Self-correction: if en = 1, SELF_CORRECT = 1 and illegal = 1, then on that edge R <= seed of mode_q, phase <= 0, wrap <= 0. No shift happens on that edge.
- Load: R <= load_val, mode_q <= mode, phase <= 0, wrap <= 0. No legality check is made at load; illegal reflects the loaded value from the next cycle.
- en = 0 and load = 0: R, phase and mode_q hold; wrap <= 0. An illegal R is held and flagged, not corrected.

## Timing
- Reset values, applied immediately on reset assertion without waiting for clk:
  - R = 1 << (WIDTH-1), mode_q = 0 (ring), phase = 0, wrap = 0, illegal = 0
- Reset mid-sequence aborts the sequence immediately.
- After reset deasserts, the first shift occurs on the first rising edge with en = 1.
- Latency: a shift, load or correction is visible on R, phase and wrap one edge after the enabling inputs are sampled.
- illegal has zero latency relative to R (combinational).
- load and en high on the same edge: load wins; no shift that cycle.
- wrap is never high for two consecutive cycles unless a wrap occurs on two consecutive shifts. This happens only if P = 1, which is impossible since P ≥ 2.

## Test plan
- Ring sweep (WIDTH 4, dir 0, en held high after reset):
  - R: 1000 → 0100 → 0010 → 0001 → 1000
  - phase: 0, 1, 2, 3, 0
  - wrap = 1 only in the cycle after 0001 → 1000
- Johnson sweep (load mode = 1, load_val = 0000, then en = 1, dir = 0):
  - R: 1000, 1100, 1110, 1111, 0111, 0011, 0001, 0000
  - phase reaches 7, then 0; wrap = 1 after the 8th shift; illegal = 0 throughout
- Reverse direction (ring, R = 1000, dir = 1, one shift):
  - R = 0001, phase = 3, wrap = 1
  - Next shift: R = 0010, phase = 2, wrap = 0
- Illegal state (load ring 1010):
  - illegal = 1 the next cycle and holds while en = 0
  - Then en = 1 → R = 1000, phase = 0, illegal = 0
  - Same stimulus with SELF_CORRECT = 0 → R = 0101, illegal stays 1
- Johnson illegal state (load mode = 1, load_val = 0100):
  - illegal = 1; en = 1 → R = 0000, phase = 0
- Reset and priority:
  - reset raised between edges mid-sweep → R = 1000 and phase = 0 before the next edge
  - load and en on the same edge → R = load_val, phase = 0, no shift
